cam_msg_tracker: RTL

- Successor to the FIX-parser CAM write controller.
- Owns the CAM write pointer and feeds write strobe, index and data to the CAM.
- Tracks message boundaries from start/end markers and frees CAM space only when the downstream consumer releases a message.
- Delineates and queues complete messages as (start, end, length) descriptors with a valid/ready handshake; drops messages on overflow or protocol error by rewinding the pointer.

---
 rtl/cam_msg_tracker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cam_msg_tracker.sv
// Circular CAM write controller: writes message beats, queues (start, end, len) descriptors,
// and frees CAM words only when the consumer pops a descriptor. Stats macro: CAM_MSG_TRACKER_STATS_EN.
module cam_msg_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DESC_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_cs_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  start_message_i,
    input  logic                  end_message_i,
    output logic                  cam_write_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [DATA_WIDTH-1:0] cam_write_data_o,
    output logic                  desc_valid_o,
    input  logic                  desc_ready_i,
    output logic [ADDR_WIDTH-1:0] desc_start_o,
    output logic [ADDR_WIDTH-1:0] desc_end_o,
    output logic [ADDR_WIDTH:0]   desc_len_o,
    output logic [ADDR_WIDTH:0]   cam_used_o,
    output logic                  overflow_o,
    output logic                  proto_err_o
`ifdef CAM_MSG_TRACKER_STATS_EN
    ,
    output logic [15:0]           msg_count_o,
    output logic [15:0]           drop_count_o
`endif
);

    localparam int QW = $clog2(DESC_DEPTH);
    localparam logic [ADDR_WIDTH:0] CAM_DEPTH_W  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [QW:0]         DESC_DEPTH_W = (QW+1)'(DESC_DEPTH);

    typedef enum logic [1:0] {IDLE, IN_MSG, DROP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] msg_start;
    logic [ADDR_WIDTH:0]   cur_len;
    logic [ADDR_WIDTH:0]   cam_used;

    logic [ADDR_WIDTH-1:0] q_start [DESC_DEPTH];
    logic [ADDR_WIDTH-1:0] q_end   [DESC_DEPTH];
    logic [ADDR_WIDTH:0]   q_len   [DESC_DEPTH];
    logic [QW-1:0]         q_rd;
    logic [QW-1:0]         q_wr;
    logic [QW:0]           q_count;

    logic                  beat, pop, q_room;
    logic                  opening, restart, continuing, stray, take, cam_full;
    logic                  ovf, wr_go, push;
    logic [ADDR_WIDTH-1:0] base_ptr, seg_start, push_end;
    logic [ADDR_WIDTH:0]   cont_len, new_len, held_used, head_len, used_next;

    assign desc_valid_o = (q_count != '0);
    assign desc_start_o = desc_valid_o ? q_start[q_rd] : '0;
    assign desc_end_o   = desc_valid_o ? q_end[q_rd]   : '0;
    assign desc_len_o   = desc_valid_o ? q_len[q_rd]   : '0;
    assign cam_used_o   = cam_used;

    // A start beat inside an open message first abandons it (pointer and space rewound),
    // then is handled exactly like a start beat from IDLE at the rewound address.
    always_comb begin
        beat       = wr_cs_i & wr_en_i;
        pop        = desc_valid_o & desc_ready_i;
        q_room     = (q_count != DESC_DEPTH_W) | pop;
        opening    = beat & start_message_i;
        restart    = opening & (state == IN_MSG);
        continuing = beat & ~start_message_i & (state == IN_MSG);
        stray      = beat & ~start_message_i & (state == IDLE);
        take       = opening | continuing;
        base_ptr   = restart ? msg_start : wr_ptr;
        seg_start  = opening ? base_ptr : msg_start;
        cont_len   = opening ? '0 : cur_len;
        new_len    = cont_len + 1'b1;
        held_used  = restart ? (cam_used - cur_len) : cam_used;
        cam_full   = (held_used == CAM_DEPTH_W);
        ovf        = take & (cam_full | (end_message_i & ~q_room));
        wr_go      = take & ~ovf;
        push       = wr_go & end_message_i;
        push_end   = seg_start + new_len[ADDR_WIDTH-1:0] - 1'b1;
        head_len   = q_len[q_rd];
        // Full check above deliberately ignores a same-cycle pop.
        used_next  = held_used;
        if (ovf)   used_next = used_next - cont_len;
        if (wr_go) used_next = used_next + 1'b1;
        if (pop)   used_next = used_next - head_len;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            msg_start         <= '0;
            cur_len           <= '0;
            cam_used          <= '0;
            cam_write_o       <= 1'b0;
            cam_write_index_o <= '0;
            cam_write_data_o  <= '0;
            overflow_o        <= 1'b0;
            proto_err_o       <= 1'b0;
        end else begin
            cam_write_o <= wr_go;
            overflow_o  <= ovf;
            proto_err_o <= stray | restart;
            cam_used    <= used_next;
            if (wr_go) begin
                cam_write_index_o <= base_ptr;
                cam_write_data_o  <= data_i;
            end
            if (opening) begin
                msg_start <= base_ptr;
            end
            if (wr_go) begin
                wr_ptr  <= base_ptr + 1'b1;
                state   <= push ? IDLE : IN_MSG;
                cur_len <= push ? '0 : new_len;
            end else if (ovf) begin
                wr_ptr  <= seg_start;
                state   <= end_message_i ? IDLE : DROP;
                cur_len <= '0;
            end else if (beat && state == DROP && end_message_i) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_start[q_wr] <= seg_start;
            q_end[q_wr]   <= push_end;
            q_len[q_wr]   <= new_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_rd    <= '0;
            q_wr    <= '0;
            q_count <= '0;
        end else begin
            if (push) q_wr <= q_wr + 1'b1;
            if (pop)  q_rd <= q_rd + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

`ifdef CAM_MSG_TRACKER_STATS_EN
    logic [16:0] msg_sum;
    logic [16:0] drop_sum;

    // A restart that then fails its commit counts as two dropped messages.
    always_comb begin
        msg_sum  = {1'b0, msg_count_o} + 17'(push);
        drop_sum = {1'b0, drop_count_o} + 17'(ovf) + 17'(restart);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            msg_count_o  <= msg_sum[16]  ? 16'hFFFF : msg_sum[15:0];
            drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule
